// File: rtl/median_wr_pkg.sv
// Shared types and default sizing for the median write controller.
package median_wr_pkg;

  localparam int DEFAULT_DATA_W = 16;
  localparam int DEFAULT_DEPTH  = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    FULL  = 2'd2
  } state_t;

endpackage

// File: rtl/median_wr_ctrl.sv
// Median write controller: takes a stream of median samples and writes them
// into a frame buffer of DEPTH entries, one sample every two cycles at most.
// A completed frame raises rd_req_o until the reader acknowledges it. In
// WRAP_MODE 0 the block stalls at a full frame until that acknowledge; in
// WRAP_MODE 1 it keeps filling and flags overflow_o if the previous frame was
// still unread.
module median_wr_ctrl
  import median_wr_pkg::*;
#(
  parameter int DATA_W    = DEFAULT_DATA_W,
  parameter int DEPTH     = DEFAULT_DEPTH,
  parameter int WRAP_MODE = 1,
  localparam int ADDR_W   = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              clear_i,
  input  logic [DATA_W-1:0] median_i,
  input  logic              valid_i,
  output logic              ready_o,
  output logic              wr_en_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [DATA_W-1:0] wr_data_o,
  output logic              frame_done_o,
  output logic              rd_req_o,
  input  logic              rd_ack_i,
  output logic              overflow_o
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t            r_state;
  logic [ADDR_W-1:0] r_count;
  logic              r_wrEn;
  logic [ADDR_W-1:0] r_wrAddr;
  logic [DATA_W-1:0] r_wrData;
  logic              r_frameDone;
  logic              r_rdReq;
  logic              r_overflow;
  logic              w_ready;
  logic              w_ackTaken;

  assign w_ready    = (r_state == IDLE);
  assign w_ackTaken = rd_ack_i && r_rdReq;

  assign ready_o      = w_ready;
  assign wr_en_o      = r_wrEn;
  assign wr_addr_o    = r_wrAddr;
  assign wr_data_o    = r_wrData;
  assign frame_done_o = r_frameDone;
  assign rd_req_o     = r_rdReq;
  assign overflow_o   = r_overflow;

  // Accept/write FSM with the inline frame counter and readout handshake;
  // later assignments win, so a frame completion overrides a same-cycle ack.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state     <= IDLE;
      r_count     <= '0;
      r_wrEn      <= 1'b0;
      r_wrAddr    <= '0;
      r_wrData    <= '0;
      r_frameDone <= 1'b0;
      r_rdReq     <= 1'b0;
      r_overflow  <= 1'b0;
    end else if (clear_i) begin
      r_state     <= IDLE;
      r_count     <= '0;
      r_wrEn      <= 1'b0;
      r_frameDone <= 1'b0;
      r_rdReq     <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_wrEn      <= 1'b0;
      r_frameDone <= 1'b0;
      if (w_ackTaken) begin
        r_rdReq <= 1'b0;
      end
      case (r_state)
        IDLE: begin
          if (valid_i && w_ready) begin
            r_wrData <= median_i;
            r_wrAddr <= r_count;
            r_wrEn   <= 1'b1;
            r_state  <= WRITE;
          end
        end
        WRITE: begin
          if (r_count == LAST_ADDR) begin
            r_count     <= '0;
            r_frameDone <= 1'b1;
            r_rdReq     <= 1'b1;
            if (r_rdReq) begin
              r_overflow <= 1'b1;
            end
            r_state <= (WRAP_MODE != 0) ? IDLE : FULL;
          end else begin
            r_count <= r_count + 1'b1;
            r_state <= IDLE;
          end
        end
        FULL: begin
          if (w_ackTaken) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // The write strobe lasts exactly one cycle, so it can never repeat back to back.
  property p_noDoubleWrite;
    @(posedge clk_i) disable iff (!rstn_i) wr_en_o |=> !wr_en_o;
  endproperty
  a_noDoubleWrite: assert property (p_noDoubleWrite);

  // Samples are only offered acceptance while the FSM is idle.
  property p_readyInIdle;
    @(posedge clk_i) disable iff (!rstn_i) ready_o |-> (r_state == IDLE);
  endproperty
  a_readyInIdle: assert property (p_readyInIdle);

endmodule

// File: tb/tb_median_wr_ctrl.sv
// Testbench for median_wr_ctrl: one instance per wrap mode, both driven by the
// same stimulus and each tracked by a transaction-level reference model.
module tb_median_wr_ctrl;

  localparam int DW = 16;
  localparam int DP = 8;
  localparam int AW = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rstn  = 1'b0;
  logic          clear = 1'b0;
  logic          valid = 1'b0;
  logic          ack   = 1'b0;
  logic [DW-1:0] din   = '0;

  logic          rdy0, wen0, done0, req0, ovf0;
  logic [AW-1:0] addr0;
  logic [DW-1:0] data0;
  logic          rdy1, wen1, done1, req1, ovf1;
  logic [AW-1:0] addr1;
  logic [DW-1:0] data1;

  median_wr_ctrl #(.DATA_W(DW), .DEPTH(DP), .WRAP_MODE(0)) dut0 (
    .clk_i(clk), .rstn_i(rstn), .clear_i(clear), .median_i(din), .valid_i(valid),
    .ready_o(rdy0), .wr_en_o(wen0), .wr_addr_o(addr0), .wr_data_o(data0),
    .frame_done_o(done0), .rd_req_o(req0), .rd_ack_i(ack), .overflow_o(ovf0)
  );

  median_wr_ctrl #(.DATA_W(DW), .DEPTH(DP), .WRAP_MODE(1)) dut1 (
    .clk_i(clk), .rstn_i(rstn), .clear_i(clear), .median_i(din), .valid_i(valid),
    .ready_o(rdy1), .wr_en_o(wen1), .wr_addr_o(addr1), .wr_data_o(data1),
    .frame_done_o(done1), .rd_req_o(req1), .rd_ack_i(ack), .overflow_o(ovf1)
  );

  // Reference view of one controller: how many samples of the current frame
  // are stored, whether a write is in flight, whether the buffer is blocked
  // waiting for the reader, plus the expected visible outputs.
  typedef struct {
    int fill;
    bit pend;
    bit blocked;
    bit req;
    bit ovf;
    bit wrEn;
    int addr;
    int data;
    bit done;
  } model_t;

  model_t mdl[2];
  int checks = 0;
  int errors = 0;
  int wrCount[2];
  int doneCount[2];
  int lastAddr[2];
  int lastData[2];

  function automatic model_t modelReset();
    model_t m;
    m.fill = 0; m.pend = 0; m.blocked = 0; m.req = 0; m.ovf = 0;
    m.wrEn = 0; m.addr = 0; m.data = 0; m.done = 0;
    return m;
  endfunction

  function automatic model_t modelStep(model_t m, bit wrap, bit c, bit v, int d, bit a);
    model_t n = m;
    n.wrEn = 0;
    n.done = 0;
    if (c) begin
      n.fill = 0; n.pend = 0; n.blocked = 0; n.req = 0; n.ovf = 0;
      return n;
    end
    if (a && m.req) begin
      n.req = 0;
      n.blocked = 0;
    end
    if (!m.pend && !m.blocked && v) begin
      n.wrEn = 1;
      n.addr = m.fill;
      n.data = d;
      n.pend = 1;
    end
    if (m.pend) begin
      n.pend = 0;
      if (m.fill + 1 == DP) begin
        n.fill = 0;
        n.done = 1;
        n.req = 1;
        if (m.req) n.ovf = 1;
        if (!wrap) n.blocked = 1;
      end else begin
        n.fill = m.fill + 1;
      end
    end
    return n;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic checkDut(input int i, input logic r, input logic we, input logic [AW-1:0] ad,
                          input logic [DW-1:0] da, input logic dn, input logic rq, input logic ov);
    checkOutput($sformatf("d%0d_ready", i), 32'(r), 32'(!mdl[i].pend && !mdl[i].blocked));
    checkOutput($sformatf("d%0d_wr_en", i), 32'(we), 32'(mdl[i].wrEn));
    checkOutput($sformatf("d%0d_wr_addr", i), 32'(ad), 32'(mdl[i].addr));
    checkOutput($sformatf("d%0d_wr_data", i), 32'(da), 32'(mdl[i].data));
    checkOutput($sformatf("d%0d_frame_done", i), 32'(dn), 32'(mdl[i].done));
    checkOutput($sformatf("d%0d_rd_req", i), 32'(rq), 32'(mdl[i].req));
    checkOutput($sformatf("d%0d_overflow", i), 32'(ov), 32'(mdl[i].ovf));
  endtask

  task automatic checkBoth();
    checkDut(0, rdy0, wen0, addr0, data0, done0, req0, ovf0);
    checkDut(1, rdy1, wen1, addr1, data1, done1, req1, ovf1);
  endtask

  // One clock of stimulus; called just after a rising edge.
  task automatic applyStimulus(input bit c, input bit v, input logic [DW-1:0] d, input bit a);
    clear = c; valid = v; din = d; ack = a;
    @(posedge clk);
    mdl[0] = modelStep(mdl[0], 1'b0, c, v, int'(d), a);
    mdl[1] = modelStep(mdl[1], 1'b1, c, v, int'(d), a);
    #1;
    checkBoth();
    if (wen0) begin wrCount[0]++; lastAddr[0] = int'(addr0); lastData[0] = int'(data0); end
    if (wen1) begin wrCount[1]++; lastAddr[1] = int'(addr1); lastData[1] = int'(data1); end
    if (done0) doneCount[0]++;
    if (done1) doneCount[1]++;
  endtask

  // Asynchronous reset pulse inside one clock period; called just after an edge.
  task automatic applyReset();
    clear = 0; valid = 0; ack = 0;
    rstn = 1'b0;
    #2;
    mdl[0] = modelReset();
    mdl[1] = modelReset();
    checkBoth();
    #2;
    rstn = 1'b1;
  endtask

  task automatic clearCounts();
    for (int i = 0; i < 2; i++) begin
      wrCount[i] = 0; doneCount[i] = 0; lastAddr[i] = -1; lastData[i] = -1;
    end
  endtask

  // Hold a sample until instance idx takes it, then spend one cycle without
  // valid (optionally acknowledging) while the write completes.
  task automatic sendSample(input int idx, input logic [DW-1:0] d, input bit ackAfter);
    int n = 0;
    bit got = 0;
    while (!got && n < 10) begin
      applyStimulus(1'b0, 1'b1, d, 1'b0);
      got = mdl[idx].wrEn;
      n++;
    end
    if (!got) checkOutput("accept_timeout", 32'd0, 32'd1);
    applyStimulus(1'b0, 1'b0, d, ackAfter);
  endtask

  initial begin
    int s;
    int n;
    @(posedge clk);
    #1;

    // Eight samples with valid held continuously.
    applyReset();
    clearCounts();
    s = 1;
    n = 0;
    while (s <= 8 && n < 40) begin
      applyStimulus(1'b0, 1'b1, 16'(s), 1'b0);
      if (mdl[1].wrEn) s++;
      n++;
    end
    applyStimulus(1'b0, 1'b0, 16'h0, 1'b0);
    applyStimulus(1'b0, 1'b0, 16'h0, 1'b0);
    checkOutput("frame_writes", 32'(wrCount[1]), 32'd8);
    checkOutput("frame_done_pulses", 32'(doneCount[1]), 32'd1);
    checkOutput("frame_last_addr", 32'(lastAddr[1]), 32'd7);
    checkOutput("frame_last_data", 32'(lastData[1]), 32'h8);
    checkOutput("frame_rd_req", 32'(req1), 32'd1);

    // Stop-at-full instance ignores samples until the reader acknowledges.
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b0, 1'b1, 16'h00AA, 1'b0);
      checkOutput("full_ready_low", 32'(rdy0), 32'd0);
    end
    checkOutput("full_no_writes", 32'(wrCount[0]), 32'd8);
    applyStimulus(1'b0, 1'b0, 16'h0, 1'b1);
    sendSample(0, 16'h00AA, 1'b0);
    checkOutput("after_ack_addr", 32'(lastAddr[0]), 32'd0);
    checkOutput("after_ack_data", 32'(lastData[0]), 32'h00AA);

    // Two frames with no acknowledge: overflow is sticky until clear.
    applyReset();
    clearCounts();
    for (int k = 0; k < 16; k++) sendSample(1, 16'(k + 16'h100), 1'b0);
    checkOutput("two_frames_done", 32'(doneCount[1]), 32'd2);
    checkOutput("two_frames_ovf", 32'(ovf1), 32'd1);
    for (int k = 0; k < 5; k++) applyStimulus(1'b0, 1'b0, 16'h0, (k == 2));
    checkOutput("ovf_sticky", 32'(ovf1), 32'd1);
    applyStimulus(1'b1, 1'b0, 16'h0, 1'b0);
    checkOutput("ovf_cleared", 32'(ovf1), 32'd0);

    // Acknowledge coinciding with a frame completion: the set wins.
    applyReset();
    clearCounts();
    for (int k = 0; k < 15; k++) sendSample(1, 16'(k), 1'b0);
    sendSample(1, 16'h00FF, 1'b1);
    checkOutput("ack_collide_req", 32'(req1), 32'd1);
    checkOutput("ack_collide_ovf", 32'(ovf1), 32'd1);

    // Reset mid-frame discards the partial frame.
    applyReset();
    clearCounts();
    for (int k = 0; k < 5; k++) sendSample(1, 16'(k + 16'h20), 1'b0);
    applyReset();
    sendSample(1, 16'h1234, 1'b0);
    checkOutput("post_reset_addr", 32'(lastAddr[1]), 32'd0);
    checkOutput("post_reset_data", 32'(lastData[1]), 32'h1234);
    checkOutput("post_reset_req", 32'(req1), 32'd0);

    // Clear beats a simultaneous valid and rewinds the address.
    applyReset();
    clearCounts();
    for (int k = 0; k < 3; k++) sendSample(1, 16'(k + 16'h40), 1'b0);
    applyStimulus(1'b1, 1'b1, 16'h5555, 1'b0);
    checkOutput("clear_no_write", 32'(wen1), 32'd0);
    checkOutput("clear_req", 32'(req1), 32'd0);
    sendSample(1, 16'h0077, 1'b0);
    checkOutput("clear_addr0", 32'(lastAddr[1]), 32'd0);

    // Randomized traffic with occasional acknowledge, clear and reset.
    for (int k = 0; k < 1200; k++) begin
      if ($urandom_range(0, 199) == 0) begin
        applyReset();
      end else begin
        applyStimulus(($urandom_range(0, 59) == 0), ($urandom_range(0, 9) < 7),
                      16'($urandom), ($urandom_range(0, 6) == 0));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/median_wr_ctrl.md
MEDIAN_WR_CTRL -- requirements
Module: median_wr_ctrl

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16, giving the sample width.
REQ-002 The block SHALL have parameter DEPTH, default 8, giving the samples per frame; legal values are powers of two, 2..256.
REQ-003 The block SHALL have parameter WRAP_MODE, default 1: 1 = continuous frames, 0 = stop at full until acknowledged.
REQ-004 The block SHALL derive localparam ADDR_W = $clog2(DEPTH).
REQ-005 The ports SHALL be, clock and reset first:
- clk_i  in  1  sole clock; one clock, all logic on the rising edge
- rstn_i  in  1  reset; asynchronous, active-low
- clear_i  in  1  synchronous soft clear
- median_i  in  DATA_W  input sample
- valid_i  in  1  sample valid
- ready_o  out  1  block can accept a sample
- wr_en_o  out  1  memory write strobe
- wr_addr_o  out  ADDR_W  memory write address
- wr_data_o  out  DATA_W  memory write data
- frame_done_o  out  1  one-cycle pulse when a frame completes
- rd_req_o  out  1  frame ready for readout; held until acknowledged
- rd_ack_i  in  1  reader acknowledge
- overflow_o  out  1  sticky: a frame completed while rd_req_o was still high

Function
REQ-006 The FSM SHALL have states IDLE, WRITE and FULL.
REQ-007 ready_o SHALL be combinational and high only in IDLE.
REQ-008 A sample SHALL be accepted at the rising edge where valid_i=1 and ready_o=1.
REQ-009 At acceptance, on the same edge:
- wr_data_o <= median_i
- wr_addr_o <= count
- wr_en_o <= 1
- the state moves to WRITE
REQ-010 wr_en_o SHALL be high for exactly the one cycle spent in WRITE, giving one-cycle latency and a maximum throughput of one sample per 2 cycles.
REQ-011 valid_i while ready_o=0 SHALL be ignored; the sender holds the sample.
REQ-012 count SHALL be ADDR_W bits and increment once per accepted sample.
REQ-013 On leaving WRITE with count = DEPTH-1, the block SHALL:
- wrap count to 0
- pulse frame_done_o for one cycle
- set rd_req_o
- set overflow_o if rd_req_o was already high
- go to FULL when WRAP_MODE=0, otherwise to IDLE
REQ-014 On leaving WRITE with count < DEPTH-1, the block SHALL return to IDLE.
REQ-015 rd_ack_i while rd_req_o=1 SHALL clear rd_req_o on the next edge; FULL SHALL exit to IDLE on that same edge.
REQ-016 rd_ack_i while rd_req_o=0 SHALL be ignored.
REQ-017 When rd_ack_i coincides with a frame completion, the set SHALL win: rd_req_o stays 1 and overflow_o is set.
REQ-018 clear_i SHALL have priority over every other input and force, on the next edge:
- state IDLE and count 0
- rd_req_o, overflow_o, wr_en_o and frame_done_o to 0
- wr_addr_o and wr_data_o unchanged
REQ-019 overflow_o SHALL be cleared only by clear_i or reset.

Reset
REQ-020 rstn_i low SHALL asynchronously force:
- state IDLE
- count 0
- wr_en_o, wr_addr_o, wr_data_o, frame_done_o, rd_req_o and overflow_o all 0
REQ-021 A reset asserted mid-frame SHALL discard the partial frame; the first sample after reset is written to address 0.
REQ-022 Release of rstn_i SHALL be honoured at the first rising edge after deassertion with no extra wait cycles.

Structure
REQ-023 Package median_wr_pkg SHALL hold the typedef state_t {IDLE, WRITE, FULL} and the default DATA_W and DEPTH constants.
REQ-024 The block SHALL be a single module with no sub-modules; the counter and FSM are inline.
REQ-025 The RTL SHALL carry assertions for:
- wr_en_o never high for two consecutive cycles
- ready_o implies state IDLE

Verification
REQ-026 Reset, then 8 samples 0x0001..0x0008, valid_i held → wr_en_o 8 times at addresses 0..7 with matching data; frame_done_o pulses once after the 8th; rd_req_o=1.
REQ-027 WRAP_MODE=0, frame filled, 3 further valid_i → ready_o=0 and no writes until rd_ack_i; then the next sample 0x00AA is written to address 0.
REQ-028 WRAP_MODE=1, 16 samples with no rd_ack_i → second frame_done_o pulse; overflow_o=1 and stays 1 until clear_i.
REQ-029 rd_ack_i asserted in the cycle of the 8th write completion → rd_req_o stays 1 and overflow_o=1.
REQ-030 rstn_i pulsed low after 5 samples, then 1 sample 0x1234 → write at address 0 with data 0x1234; rd_req_o=0.
REQ-031 clear_i together with valid_i in IDLE → sample not written; all flags 0; count 0.
